// File: rtl/emu_time_mgr.sv
// Emulator timestep arbiter: grants the smallest enabled dt request, tracks
// absolute emulated time and step count, and handles pause / stop-at-time.

// Per-requester masking: a disabled requester presents DT_MAX, so it never
// wins the min tree.
module emu_dt_lane #(
  parameter int DT_WIDTH = 16
) (
  input  logic                en,
  input  logic [DT_WIDTH-1:0] req,
  output logic [DT_WIDTH-1:0] eff
);
  assign eff = en ? req : {DT_WIDTH{1'b1}};
endmodule

module emu_time_mgr #(
  parameter int N_REQ      = 2,
  parameter int DT_WIDTH   = 16,
  parameter int TIME_WIDTH = 32,
  parameter int STEP_WIDTH = 32
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst_n,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          req_en,
  input  logic                      pause,
  input  logic                      stop_en,
  input  logic [TIME_WIDTH-1:0]     t_stop,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic [STEP_WIDTH-1:0]     step_cnt,
  output logic                      running,
  output logic                      done
);
  typedef enum logic [1:0] {RUN, PAUSED, STOPPED} state_t;

  localparam logic [TIME_WIDTH-1:0] T_ONES = {TIME_WIDTH{1'b1}};
  localparam logic [DT_WIDTH-1:0]   DT_MAX = {DT_WIDTH{1'b1}};

  state_t state, state_nxt;

  logic [N_REQ-1:0][DT_WIDTH-1:0] lane_dt;
  logic [DT_WIDTH-1:0]            req_min;
  logic [TIME_WIDTH-1:0]          cand, rem, headroom, time_nxt;
  logic                           stop_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    emu_dt_lane #(.DT_WIDTH(DT_WIDTH)) u_lane (
      .en  (req_en[i]),
      .req (dt_req[i*DT_WIDTH +: DT_WIDTH]),
      .eff (lane_dt[i])
    );
  end

  // Min over all lanes; empty enable mask naturally yields DT_MAX.
  always_comb begin
    req_min = DT_MAX;
    for (int i = 0; i < N_REQ; i++)
      if (lane_dt[i] < req_min) req_min = lane_dt[i];
  end

  // Granted step: gated by state/pause/reset, clipped to stop time and to
  // the remaining time headroom so emu_time lands exactly and saturates.
  always_comb begin
    rem      = (t_stop > emu_time) ? (t_stop - emu_time) : '0;
    headroom = T_ONES - emu_time;
    cand     = {{(TIME_WIDTH-DT_WIDTH){1'b0}}, req_min};
    if (stop_en && rem < cand) cand = rem;
    if (headroom < cand)       cand = headroom;
    if (!emu_rst_n || state != RUN || pause) cand = '0;
    emu_dt   = cand[DT_WIDTH-1:0];
    time_nxt = emu_time + cand;
  end

  // Next state; pause has priority, then stop (explicit or saturation).
  always_comb begin
    state_nxt = state;
    stop_hit  = (stop_en && time_nxt >= t_stop) || (time_nxt == T_ONES);
    unique case (state)
      RUN:     if (pause) state_nxt = PAUSED;
               else if (stop_hit) state_nxt = STOPPED;
      PAUSED:  if (!pause) state_nxt = stop_hit ? STOPPED : RUN;
      STOPPED: if (pause) state_nxt = PAUSED;
               else if ((!stop_en || t_stop > emu_time) && emu_time != T_ONES)
                 state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State, time and step counter registers.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state    <= RUN;
      emu_time <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      emu_time <= time_nxt;
      if (emu_dt != '0) step_cnt <= step_cnt + 1'b1;
    end
  end

  assign running = emu_rst_n && (state == RUN);
  assign done    = emu_rst_n && (state == STOPPED);
endmodule
